axi4_lite_regif: RTL and testbench
==================================

# axi4_lite_regif

Parametrised AXI4-Lite slave that converts bus transactions into single-cycle-handshake register read/write requests for a peripheral's register file. It generalises the earlier fixed 16-register slave: configurable address and register-index width, AW and W accepted independently in any order, DECERR for unmapped addresses, and an optional acknowledge timeout that returns SLVERR. It sits between the interconnect and the peripheral's register block; the read and write paths are fully independent.

## Interface
- `ADDR_BITS`, 8: AXI byte-address width; must be ≥ `REG_ADDR_BITS`+2.
- `REG_ADDR_BITS`, 4: register word-index width.
- `NUM_REGS`, 16: number of mapped registers; must be ≤ 2^`REG_ADDR_BITS`.
- `ACK_TIMEOUT`, 15: cycles to wait for `wr_ack`/`rd_ack` before SLVERR; must be ≥ 1.

- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `s_axi_awaddr` in `ADDR_BITS`; `s_axi_awvalid` in 1; `s_axi_awready` out 1.
- `s_axi_wdata` in 32; `s_axi_wstrb` in 4; `s_axi_wvalid` in 1; `s_axi_wready` out 1.
- `s_axi_bresp` out 2; `s_axi_bvalid` out 1; `s_axi_bready` in 1.
- `s_axi_araddr` in `ADDR_BITS`; `s_axi_arvalid` in 1; `s_axi_arready` out 1.
- `s_axi_rdata` out 32; `s_axi_rresp` out 2; `s_axi_rvalid` out 1; `s_axi_rready` in 1.
- `wr_addr` out `REG_ADDR_BITS`: write register index; `wr_en` out 1; `wr_data` out 32; `wr_strb` out 4; `wr_ack` in 1.
- `rd_addr` out `REG_ADDR_BITS`: read register index; `rd_en` out 1; `rd_data` in 32; `rd_ack` in 1.

## Operation
- Address decode: index = addr[`REG_ADDR_BITS`+1:2]; addr[1:0] ignored. Decode error if index ≥ `NUM_REGS` or any addr bit above `REG_ADDR_BITS`+1 is nonzero.
- Write FSM: `WR_IDLE` → `WR_EXEC` → `WR_RESP` → `WR_IDLE`.
  - `WR_IDLE`: `s_axi_awready` = !aw_held, `s_axi_wready` = !w_held. AW handshake latches `wr_addr` and sets aw_held; W handshake latches `wr_data`/`wr_strb` and sets w_held. Either order; both handshakes in the same cycle allowed.
  - Once both are held: to `WR_EXEC` if the address decodes; otherwise to `WR_RESP` with `bresp`=2'b11, never asserting `wr_en`. Flags are cleared on the transition.
  - `WR_EXEC`: `wr_en`=1 continuously. `wr_ack`=1 → `WR_RESP`, `bresp`=2'b00.
  - `WR_RESP`: `bvalid`=1, `bresp` stable; `bready`=1 → `WR_IDLE`.
- Read FSM: `RD_IDLE` → `RD_EXEC` → `RD_RESP` → `RD_IDLE`.
  - `RD_IDLE`: `arready`=1. Handshake latches `rd_addr`. Decode OK → `RD_EXEC`; decode error → `RD_RESP` with `rdata`=0, `rresp`=2'b11.
  - `RD_EXEC`: `rd_en`=1. `rd_ack`=1 → capture `rd_data` into `s_axi_rdata`, `rresp`=2'b00, → `RD_RESP`.
  - `RD_RESP`: `rvalid`=1, `rdata`/`rresp` stable; `rready`=1 → `RD_IDLE` and `rdata` cleared to 0.
- `wr_ack`/`rd_ack` are ignored outside the respective `EXEC` state. Read and write may be active in the same cycle.

## Timing
- Reset: all states go idle. `awready`, `wready`, `arready`=1. `bvalid`, `rvalid`, `wr_en`, `rd_en`=0. `bresp`, `rresp`, `rdata`, `wr_addr`, `wr_data`, `wr_strb`, `rd_addr`=0. Held flags and timeout counter are cleared.
- Reset mid-transaction aborts it; no response is issued.
- Write latency: last of AW/W handshakes in cycle N → `wr_en` in N+1. `wr_ack` in cycle M → `bvalid` in M+1. Minimum: handshake at 0, ack at 1, `bvalid` at 2.
- Read latency: AR handshake at N → `rd_en` at N+1. `rd_ack` at M → `rvalid` at M+1.
- DECERR path: `bvalid`/`rvalid` asserted the cycle after the completing handshake.
- All outputs are registered or decoded directly from state; no combinational path from inputs to outputs.

## Configuration
- `AXIL_REGIF_TIMEOUT_EN` defined: each `EXEC` state has a counter of width $clog2(`ACK_TIMEOUT`+1), cleared on entry.
  - After `ACK_TIMEOUT` cycles in `EXEC` with no ack, the FSM leaves `EXEC` and responds with 2'b10 (SLVERR); for reads `rdata`=0.
  - An ack in the same cycle the timeout expires wins and gives OKAY.
- Macro undefined: no counters; `EXEC` waits for the ack indefinitely. SLVERR is never generated.

## Test plan
- W handshake before AW (addr 0x08, data 0xDEADBEEF, strb 0xF); ack in the first `wr_en` cycle → `wr_addr`=2, data/strb match, `bvalid` 1 cycle later with `bresp`=00.
- AW and W in the same cycle with addr 0x40 (`NUM_REGS`=16) → `wr_en` never asserted; next cycle `bvalid`=1, `bresp`=11.
- Read addr 0x0C, `rd_ack` after 3 cycles with `rd_data`=0x12345678; `rready` held low 4 cycles → `rvalid`, `rdata`, `rresp`=00 held stable; `rdata`=0 after the handshake.
- With `AXIL_REGIF_TIMEOUT_EN` and `ACK_TIMEOUT`=15, no `wr_ack` → `wr_en` high exactly 15 cycles, then `bresp`=10. Repeat with ack on cycle 15 → `bresp`=00.
- Concurrent read and write to the same register → both complete independently with OKAY.
- Assert `rst_n` low while in `WR_EXEC` → `wr_en` drops immediately; after release, `awready`=`wready`=1 and no `bvalid` is issued.

Source files
------------

// File: rtl/axi4_lite_regif.sv
// AXI4-Lite slave that turns bus transactions into single-cycle-handshake register requests.
// Optional acknowledge timeout (SLVERR) is enabled by defining AXIL_REGIF_TIMEOUT_EN.
module axi4_lite_regif #(
  parameter int ADDR_BITS     = 8,
  parameter int REG_ADDR_BITS = 4,
  parameter int NUM_REGS      = 16,
  parameter int ACK_TIMEOUT   = 15
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [ADDR_BITS-1:0]     s_axi_awaddr,
  input  logic                     s_axi_awvalid,
  output logic                     s_axi_awready,
  input  logic [31:0]              s_axi_wdata,
  input  logic [3:0]               s_axi_wstrb,
  input  logic                     s_axi_wvalid,
  output logic                     s_axi_wready,
  output logic [1:0]               s_axi_bresp,
  output logic                     s_axi_bvalid,
  input  logic                     s_axi_bready,
  input  logic [ADDR_BITS-1:0]     s_axi_araddr,
  input  logic                     s_axi_arvalid,
  output logic                     s_axi_arready,
  output logic [31:0]              s_axi_rdata,
  output logic [1:0]               s_axi_rresp,
  output logic                     s_axi_rvalid,
  input  logic                     s_axi_rready,
  output logic [REG_ADDR_BITS-1:0] wr_addr,
  output logic                     wr_en,
  output logic [31:0]              wr_data,
  output logic [3:0]               wr_strb,
  input  logic                     wr_ack,
  output logic [REG_ADDR_BITS-1:0] rd_addr,
  output logic                     rd_en,
  input  logic [31:0]              rd_data,
  input  logic                     rd_ack
);

  typedef enum logic [1:0] {WR_IDLE, WR_EXEC, WR_RESP} wr_state_e;
  typedef enum logic [1:0] {RD_IDLE, RD_EXEC, RD_RESP} rd_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [REG_ADDR_BITS:0] NUM_REGS_L = (REG_ADDR_BITS+1)'(NUM_REGS);

`ifdef AXIL_REGIF_TIMEOUT_EN
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);
`endif

  // Byte lanes addr[1:0] carry no register information.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

  function automatic logic decode_err(input logic [ADDR_BITS-1:0] addr);
    logic [REG_ADDR_BITS-1:0] idx;
    idx = addr[REG_ADDR_BITS+1:2];
    decode_err = ({1'b0, idx} >= NUM_REGS_L) || ((addr >> (REG_ADDR_BITS + 2)) != '0);
  endfunction

  // ---------------- write path ----------------
  wr_state_e                wr_state_q, wr_state_d;
  logic                     aw_held_q, aw_held_d;
  logic                     w_held_q, w_held_d;
  logic                     aw_err_q, aw_err_d;
  logic [REG_ADDR_BITS-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]              wr_data_q, wr_data_d;
  logic [3:0]               wr_strb_q, wr_strb_d;
  logic [1:0]               bresp_q, bresp_d;
`ifdef AXIL_REGIF_TIMEOUT_EN
  logic [CNT_W-1:0]         wr_cnt_q, wr_cnt_d;
`endif

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    wr_state_d = wr_state_q;
    aw_held_d  = aw_held_q;
    w_held_d   = w_held_q;
    aw_err_d   = aw_err_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    wr_strb_d  = wr_strb_q;
    bresp_d    = bresp_q;
`ifdef AXIL_REGIF_TIMEOUT_EN
    wr_cnt_d   = wr_cnt_q;
`endif
    case (wr_state_q)
      WR_IDLE: begin
        if (s_axi_awvalid && !aw_held_q) begin
          aw_held_d = 1'b1;
          wr_addr_d = s_axi_awaddr[REG_ADDR_BITS+1:2];
          aw_err_d  = decode_err(s_axi_awaddr);
        end
        if (s_axi_wvalid && !w_held_q) begin
          w_held_d  = 1'b1;
          wr_data_d = s_axi_wdata;
          wr_strb_d = s_axi_wstrb;
        end
        // The last of the two handshakes launches the request in the same cycle.
        if (aw_held_d && w_held_d) begin
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          if (aw_err_d) begin
            wr_state_d = WR_RESP;
            bresp_d    = RESP_DECERR;
          end else begin
            wr_state_d = WR_EXEC;
`ifdef AXIL_REGIF_TIMEOUT_EN
            wr_cnt_d   = '0;
`endif
          end
        end
      end
      WR_EXEC: begin
        if (wr_ack) begin
          wr_state_d = WR_RESP;
          bresp_d    = RESP_OKAY;
        end
`ifdef AXIL_REGIF_TIMEOUT_EN
        else if (wr_cnt_q == CNT_LAST) begin
          wr_state_d = WR_RESP;
          bresp_d    = RESP_SLVERR;
        end else begin
          wr_cnt_d = wr_cnt_q + CNT_W'(1);
        end
`endif
      end
      WR_RESP: begin
        if (s_axi_bready) wr_state_d = WR_IDLE;
      end
      default: wr_state_d = WR_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state_q <= WR_IDLE;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      aw_err_q   <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      wr_strb_q  <= '0;
      bresp_q    <= '0;
`ifdef AXIL_REGIF_TIMEOUT_EN
      wr_cnt_q   <= '0;
`endif
    end else begin
      wr_state_q <= wr_state_d;
      aw_held_q  <= aw_held_d;
      w_held_q   <= w_held_d;
      aw_err_q   <= aw_err_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      wr_strb_q  <= wr_strb_d;
      bresp_q    <= bresp_d;
`ifdef AXIL_REGIF_TIMEOUT_EN
      wr_cnt_q   <= wr_cnt_d;
`endif
    end
  end

  assign s_axi_awready = (wr_state_q == WR_IDLE) && !aw_held_q;
  assign s_axi_wready  = (wr_state_q == WR_IDLE) && !w_held_q;
  assign s_axi_bvalid  = (wr_state_q == WR_RESP);
  assign s_axi_bresp   = bresp_q;
  assign wr_en         = (wr_state_q == WR_EXEC);
  assign wr_addr       = wr_addr_q;
  assign wr_data       = wr_data_q;
  assign wr_strb       = wr_strb_q;

  // ---------------- read path ----------------
  rd_state_e                rd_state_q, rd_state_d;
  logic [REG_ADDR_BITS-1:0] rd_addr_q, rd_addr_d;
  logic [31:0]              rdata_q, rdata_d;
  logic [1:0]               rresp_q, rresp_d;
`ifdef AXIL_REGIF_TIMEOUT_EN
  logic [CNT_W-1:0]         rd_cnt_q, rd_cnt_d;
`endif

  always_comb begin
    rd_state_d = rd_state_q;
    rd_addr_d  = rd_addr_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
`ifdef AXIL_REGIF_TIMEOUT_EN
    rd_cnt_d   = rd_cnt_q;
`endif
    case (rd_state_q)
      RD_IDLE: begin
        if (s_axi_arvalid) begin
          rd_addr_d = s_axi_araddr[REG_ADDR_BITS+1:2];
          if (decode_err(s_axi_araddr)) begin
            rd_state_d = RD_RESP;
            rdata_d    = '0;
            rresp_d    = RESP_DECERR;
          end else begin
            rd_state_d = RD_EXEC;
`ifdef AXIL_REGIF_TIMEOUT_EN
            rd_cnt_d   = '0;
`endif
          end
        end
      end
      RD_EXEC: begin
        if (rd_ack) begin
          rd_state_d = RD_RESP;
          rdata_d    = rd_data;
          rresp_d    = RESP_OKAY;
        end
`ifdef AXIL_REGIF_TIMEOUT_EN
        else if (rd_cnt_q == CNT_LAST) begin
          rd_state_d = RD_RESP;
          rdata_d    = '0;
          rresp_d    = RESP_SLVERR;
        end else begin
          rd_cnt_d = rd_cnt_q + CNT_W'(1);
        end
`endif
      end
      RD_RESP: begin
        if (s_axi_rready) begin
          rd_state_d = RD_IDLE;
          rdata_d    = '0;
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state_q <= RD_IDLE;
      rd_addr_q  <= '0;
      rdata_q    <= '0;
      rresp_q    <= '0;
`ifdef AXIL_REGIF_TIMEOUT_EN
      rd_cnt_q   <= '0;
`endif
    end else begin
      rd_state_q <= rd_state_d;
      rd_addr_q  <= rd_addr_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
`ifdef AXIL_REGIF_TIMEOUT_EN
      rd_cnt_q   <= rd_cnt_d;
`endif
    end
  end

  assign s_axi_arready = (rd_state_q == RD_IDLE);
  assign s_axi_rvalid  = (rd_state_q == RD_RESP);
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;
  assign rd_en         = (rd_state_q == RD_EXEC);
  assign rd_addr       = rd_addr_q;

endmodule

// File: tb/tb_axi4_lite_regif.sv
// Self-checking bench for axi4_lite_regif: directed vector table, corner sequences and
// randomized traffic against a byte-lane register-file model.
module tb_axi4_lite_regif;
  localparam int AB  = 8;
  localparam int RAB = 4;
  localparam int NR  = 16;
  localparam int TO  = 15;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [AB-1:0]  s_axi_awaddr, s_axi_araddr;
  logic           s_axi_awvalid, s_axi_awready, s_axi_wvalid, s_axi_wready;
  logic [31:0]    s_axi_wdata, s_axi_rdata, wr_data, rd_data;
  logic [3:0]     s_axi_wstrb, wr_strb;
  logic [1:0]     s_axi_bresp, s_axi_rresp;
  logic           s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
  logic           s_axi_rvalid, s_axi_rready;
  logic [RAB-1:0] wr_addr, rd_addr;
  logic           wr_en, wr_ack, rd_en, rd_ack;

  axi4_lite_regif #(.ADDR_BITS(AB), .REG_ADDR_BITS(RAB), .NUM_REGS(NR), .ACK_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .wr_addr(wr_addr), .wr_en(wr_en), .wr_data(wr_data), .wr_strb(wr_strb), .wr_ack(wr_ack),
    .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data), .rd_ack(rd_ack)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] periph_mem [NR];
  logic [31:0] model_mem  [NR];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference decode: mapped iff the word index is below NR and the byte address fits the window.
  function automatic logic [1:0] model_resp(input logic [7:0] addr);
    int a = int'(addr);
    if ((a / 4) >= NR || a >= (4 << RAB)) return 2'b11;
    return 2'b00;
  endfunction

  function automatic void model_write(input logic [7:0] addr, input logic [31:0] data,
                                      input logic [3:0] strb);
    int idx = int'(addr) / 4;
    if (model_resp(addr) != 2'b00) return;
    for (int b = 0; b < 4; b++)
      if (strb[b]) model_mem[idx][8*b +: 8] = data[8*b +: 8];
  endfunction

  // order: 0 = AW before W, 1 = W before AW, 2 = same cycle. ack_dly < 0 means never ack.
  task automatic do_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int order, input int ack_dly, input int hold,
                          output logic [1:0] resp, output int lat, output int en_cycles);
    int n;
    logic aw_f, w_f;
    resp = 2'bxx; lat = -1; en_cycles = 0;
    if (order != 1) begin s_axi_awaddr = addr; s_axi_awvalid = 1'b1; end
    if (order != 0) begin s_axi_wdata = data; s_axi_wstrb = strb; s_axi_wvalid = 1'b1; end
    n = 0;
    while ((s_axi_awvalid || s_axi_wvalid) && n < 20) begin
      aw_f = s_axi_awvalid && s_axi_awready;
      w_f  = s_axi_wvalid && s_axi_wready;
      @(negedge clk); n++;
      if (aw_f) begin
        s_axi_awvalid = 1'b0;
        if (order == 0) begin s_axi_wdata = data; s_axi_wstrb = strb; s_axi_wvalid = 1'b1; end
      end
      if (w_f) begin
        s_axi_wvalid = 1'b0;
        if (order == 1) begin s_axi_awaddr = addr; s_axi_awvalid = 1'b1; end
      end
    end
    if (s_axi_awvalid || s_axi_wvalid) begin
      check("wr_handshake_timeout", 32'd0, 32'd1);
      s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
      return;
    end
    n = 0;
    while (!s_axi_bvalid && n < 100) begin
      if (wr_en) begin
        if (en_cycles == 0) begin
          check("wr_addr", 32'(wr_addr), 32'(addr[5:2]));
          check("wr_data", wr_data, data);
          check("wr_strb", 32'(wr_strb), 32'(strb));
        end
        wr_ack = (en_cycles == ack_dly);
        if (wr_ack)
          for (int b = 0; b < 4; b++)
            if (wr_strb[b]) periph_mem[wr_addr][8*b +: 8] = wr_data[8*b +: 8];
        en_cycles++;
      end else begin
        wr_ack = 1'b0;
      end
      @(negedge clk); n++;
    end
    wr_ack = 1'b0;
    if (!s_axi_bvalid) begin check("bvalid_timeout", 32'd0, 32'd1); return; end
    lat = n; resp = s_axi_bresp;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("bvalid_hold", 32'(s_axi_bvalid), 32'd1);
      check("bresp_hold", 32'(s_axi_bresp), 32'(resp));
    end
    s_axi_bready = 1'b1;
    @(negedge clk);
    s_axi_bready = 1'b0;
    check("bvalid_drop", 32'(s_axi_bvalid), 32'd0);
  endtask

  task automatic do_read(input logic [7:0] addr, input int ack_dly, input int hold,
                         output logic [1:0] resp, output logic [31:0] rdata, output int lat);
    int n, en_cycles;
    logic f;
    resp = 2'bxx; rdata = 'x; lat = -1; en_cycles = 0;
    s_axi_araddr = addr; s_axi_arvalid = 1'b1;
    n = 0;
    while (s_axi_arvalid && n < 20) begin
      f = s_axi_arready;
      @(negedge clk); n++;
      if (f) s_axi_arvalid = 1'b0;
    end
    if (s_axi_arvalid) begin
      check("ar_handshake_timeout", 32'd0, 32'd1);
      s_axi_arvalid = 1'b0;
      return;
    end
    n = 0;
    while (!s_axi_rvalid && n < 100) begin
      if (rd_en) begin
        if (en_cycles == 0) check("rd_addr", 32'(rd_addr), 32'(addr[5:2]));
        rd_ack  = (en_cycles == ack_dly);
        rd_data = rd_ack ? periph_mem[rd_addr] : $urandom;
        en_cycles++;
      end else begin
        rd_ack = 1'b0;
      end
      @(negedge clk); n++;
    end
    rd_ack = 1'b0;
    if (!s_axi_rvalid) begin check("rvalid_timeout", 32'd0, 32'd1); return; end
    lat = n; resp = s_axi_rresp; rdata = s_axi_rdata;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("rvalid_hold", 32'(s_axi_rvalid), 32'd1);
      check("rdata_hold", s_axi_rdata, rdata);
      check("rresp_hold", 32'(s_axi_rresp), 32'(resp));
    end
    s_axi_rready = 1'b1;
    @(negedge clk);
    s_axi_rready = 1'b0;
    check("rvalid_drop", 32'(s_axi_rvalid), 32'd0);
    check("rdata_cleared", s_axi_rdata, 32'd0);
  endtask

  typedef struct {
    bit          wr;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          order;
    int          dly;
    int          hold;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t tbl [11];

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  r1, r2;
    logic [31:0] d2;
    int          l1, l2, e1;
    logic [7:0]  a;
    logic [31:0] d;
    logic [3:0]  s;

    tbl[0]  = '{1, 8'h08, 32'hDEADBEEF, 4'hF, 1, 0, 0, 2'b00, 32'h0};
    tbl[1]  = '{1, 8'h40, 32'h11111111, 4'hF, 2, 0, 1, 2'b11, 32'h0};
    tbl[2]  = '{1, 8'h0C, 32'h12345678, 4'hF, 0, 2, 0, 2'b00, 32'h0};
    tbl[3]  = '{1, 8'h0C, 32'hAABBCCDD, 4'h5, 2, 1, 2, 2'b00, 32'h0};
    tbl[4]  = '{0, 8'h0C, 32'h0,        4'h0, 0, 3, 4, 2'b00, 32'h12BB56DD};
    tbl[5]  = '{0, 8'h08, 32'h0,        4'h0, 0, 0, 0, 2'b00, 32'hDEADBEEF};
    tbl[6]  = '{0, 8'h40, 32'h0,        4'h0, 0, 0, 2, 2'b11, 32'h0};
    tbl[7]  = '{0, 8'hFC, 32'h0,        4'h0, 0, 0, 0, 2'b11, 32'h0};
    tbl[8]  = '{1, 8'h3D, 32'h0F0F0F0F, 4'hF, 0, 0, 0, 2'b00, 32'h0};
    tbl[9]  = '{0, 8'h3C, 32'h0,        4'h0, 0, 1, 1, 2'b00, 32'h0F0F0F0F};
    tbl[10] = '{0, 8'h00, 32'h0,        4'h0, 0, 0, 0, 2'b00, 32'h0};

    for (int i = 0; i < NR; i++) begin periph_mem[i] = '0; model_mem[i] = '0; end
    rst_n = 1'b0;
    s_axi_awaddr = '0; s_axi_awvalid = 1'b0; s_axi_wdata = '0; s_axi_wstrb = '0;
    s_axi_wvalid = 1'b0; s_axi_bready = 1'b0; s_axi_araddr = '0; s_axi_arvalid = 1'b0;
    s_axi_rready = 1'b0; wr_ack = 1'b0; rd_ack = 1'b0; rd_data = '0;

    repeat (2) @(negedge clk);
    check("rst_awready", 32'(s_axi_awready), 32'd1);
    check("rst_wready",  32'(s_axi_wready),  32'd1);
    check("rst_arready", 32'(s_axi_arready), 32'd1);
    check("rst_bvalid",  32'(s_axi_bvalid),  32'd0);
    check("rst_rvalid",  32'(s_axi_rvalid),  32'd0);
    check("rst_wr_en",   32'(wr_en),         32'd0);
    check("rst_rd_en",   32'(rd_en),         32'd0);
    check("rst_bresp",   32'(s_axi_bresp),   32'd0);
    check("rst_rresp",   32'(s_axi_rresp),   32'd0);
    check("rst_rdata",   s_axi_rdata,        32'd0);
    check("rst_wr_addr", 32'(wr_addr),       32'd0);
    check("rst_wr_data", wr_data,            32'd0);
    check("rst_wr_strb", 32'(wr_strb),       32'd0);
    check("rst_rd_addr", 32'(rd_addr),       32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vector table.
    for (int i = 0; i < 11; i++) begin
      if (tbl[i].wr) begin
        do_write(tbl[i].addr, tbl[i].data, tbl[i].strb, tbl[i].order, tbl[i].dly, tbl[i].hold,
                 r1, l1, e1);
        check($sformatf("tbl%0d_bresp", i), 32'(r1), 32'(tbl[i].exp_resp));
        check($sformatf("tbl%0d_wlat", i), 32'(l1),
              (tbl[i].exp_resp == 2'b11) ? 32'd0 : 32'(tbl[i].dly + 1));
        check($sformatf("tbl%0d_wr_en_cycles", i), 32'(e1),
              (tbl[i].exp_resp == 2'b11) ? 32'd0 : 32'(tbl[i].dly + 1));
        if (tbl[i].exp_resp == 2'b00) model_write(tbl[i].addr, tbl[i].data, tbl[i].strb);
      end else begin
        do_read(tbl[i].addr, tbl[i].dly, tbl[i].hold, r1, d2, l1);
        check($sformatf("tbl%0d_rresp", i), 32'(r1), 32'(tbl[i].exp_resp));
        check($sformatf("tbl%0d_rdata", i), d2, tbl[i].exp_rdata);
        check($sformatf("tbl%0d_rlat", i), 32'(l1),
              (tbl[i].exp_resp == 2'b11) ? 32'd0 : 32'(tbl[i].dly + 1));
      end
    end

    // Concurrent read and write to the same register.
    fork
      do_write(8'h10, 32'hCAFEF00D, 4'hF, 2, 2, 1, r1, l1, e1);
      do_read(8'h10, 1, 1, r2, d2, l2);
    join
    check("conc_bresp", 32'(r1), 32'd0);
    check("conc_rresp", 32'(r2), 32'd0);
    model_write(8'h10, 32'hCAFEF00D, 4'hF);
    do_read(8'h10, 0, 0, r2, d2, l2);
    check("conc_readback", d2, 32'hCAFEF00D);

    // Randomized traffic against the register-file model.
    for (int i = 0; i < 40; i++) begin
      a = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 63));
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom; s = 4'($urandom);
        do_write(a, d, s, int'($urandom_range(0, 2)), int'($urandom_range(0, 4)),
                 int'($urandom_range(0, 2)), r1, l1, e1);
        check($sformatf("rnd%0d_bresp", i), 32'(r1), 32'(model_resp(a)));
        model_write(a, d, s);
      end else begin
        do_read(a, int'($urandom_range(0, 4)), int'($urandom_range(0, 2)), r1, d2, l1);
        check($sformatf("rnd%0d_rresp", i), 32'(r1), 32'(model_resp(a)));
        check($sformatf("rnd%0d_rdata", i), d2,
              (model_resp(a) == 2'b00) ? model_mem[int'(a) / 4] : 32'd0);
      end
    end

`ifdef AXIL_REGIF_TIMEOUT_EN
    do_write(8'h20, 32'h55AA55AA, 4'hF, 2, -1, 0, r1, l1, e1);
    check("to_wr_bresp", 32'(r1), 32'd2);
    check("to_wr_en_cycles", 32'(e1), 32'(TO));
    do_write(8'h20, 32'h77777777, 4'hF, 2, TO - 1, 0, r1, l1, e1);
    check("to_ack_last_bresp", 32'(r1), 32'd0);
    check("to_ack_last_en_cycles", 32'(e1), 32'(TO));
    model_write(8'h20, 32'h77777777, 4'hF);
    do_read(8'h20, -1, 0, r1, d2, l1);
    check("to_rd_rresp", 32'(r1), 32'd2);
    check("to_rd_rdata", d2, 32'd0);
    check("to_rd_lat", 32'(l1), 32'(TO));
`endif

    // Reset while a write is executing: request drops at once, no response afterwards.
    s_axi_awaddr = 8'h14; s_axi_awvalid = 1'b1;
    s_axi_wdata = 32'h0BADF00D; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
    @(negedge clk);
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    check("rstx_wr_en_before", 32'(wr_en), 32'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rstx_wr_en_drop", 32'(wr_en), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    s_axi_bready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rstx_no_bvalid", 32'(s_axi_bvalid), 32'd0);
    end
    s_axi_bready = 1'b0;
    check("rstx_awready", 32'(s_axi_awready), 32'd1);
    check("rstx_wready", 32'(s_axi_wready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
